// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package sseg_scan_ctrl_pkg;

  // Segment vector {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg_t;

  // All segments off.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Hex glyphs 0..F, active-low; entry N is the pattern for nibble N.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Phase within one digit slot.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  // Nibble to segment pattern.
  function automatic seg_t seg_lookup(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Bus between the lab datapath and the scan controller / display pins.
interface sseg_scan_ctrl_if
  import sseg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic [NUM_DIGITS-1:0]   an;
  seg_t                    sseg;
  logic                    dp;
  logic                    frame_start;

  // Datapath side: supplies display data, observes the pins.
  modport master (
    output digits, dp_in, digit_en, load,
    input  an, sseg, dp, frame_start
  );

  // Controller side.
  modport slave (
    input  digits, dp_in, digit_en, load,
    output an, sseg, dp, frame_start
  );

endinterface

// File: rtl/sseg_scan_ctrl_hex_to_sseg.sv
// Combinational hex nibble to 7-segment decoder.
module hex_to_sseg
  import sseg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  assign seg_o = seg_lookup(nib_i);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Each digit owns a fixed slot; the first BLANK_CYCLES of every slot keep all
// anodes off to avoid ghosting. Display data is double-buffered and only
// swapped in at the start of slot 0 so a frame never shows mixed data.
module sseg_scan_ctrl
  import sseg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  sseg_scan_ctrl_if.slave    bus
);

  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  // Position of the cycle the next clock edge will present on the outputs.
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;

  // Pending buffer, written by load.
  logic                      pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0]   pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]     pend_en_q, pend_en_d;

  // Active buffer, the one being displayed.
  logic [4*NUM_DIGITS-1:0]   act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]     act_en_q, act_en_d;

  // Registered pin drivers.
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  seg_t                      sseg_q, sseg_d;
  logic                      dp_q, dp_d;
  logic                      fs_q, fs_d;

  phase_t                    phase;
  logic                      frame_first;
  logic [3:0]                cur_nib;
  seg_t                      cur_seg;

  assign frame_first = (cnt_q == '0) && (slot_q == '0);
  assign cur_nib     = act_dig_q[4*int'(slot_q) +: 4];

  hex_to_sseg u_dec (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

  // Slot phase from the position within the slot.
  always_comb begin
    phase = PH_SHOW;
    if (cnt_q < CNT_BLANK) begin
      phase = PH_BLANK;
    end
  end

  // Next position: cnt wraps each slot, slot wraps each frame.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // Double buffer: swap at the frame boundary, then let a same-cycle load refill pending.
  always_comb begin
    pend_d     = pend_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_en_d  = pend_en_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    if (frame_first && pend_q) begin
      act_dig_d = pend_dig_q;
      act_dp_d  = pend_dp_q;
      act_en_d  = pend_en_q;
      pend_d    = 1'b0;
    end
    if (bus.load) begin
      pend_dig_d = bus.digits;
      pend_dp_d  = bus.dp_in;
      pend_en_d  = bus.digit_en;
      pend_d     = 1'b1;
    end
  end

  // Output decode for the position being presented; blank unless in SHOW.
  always_comb begin
    an_d   = '1;
    sseg_d = SEG_BLANK;
    dp_d   = 1'b1;
    fs_d   = frame_first;
    if (phase == PH_SHOW) begin
      if (act_en_q[slot_q]) begin
        an_d[slot_q] = 1'b0;
      end
      sseg_d = cur_seg;
      dp_d   = ~act_dp_q[slot_q];
    end
  end

  // Scan position and buffer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      slot_q     <= '0;
      pend_q     <= 1'b0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      pend_q     <= pend_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_en_q  <= pend_en_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
    end
  end

  // Pin registers; reset forces everything dark immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= '1;
      sseg_q <= SEG_BLANK;
      dp_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
      dp_q   <= dp_d;
      fs_q   <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.sseg        = sseg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule
